// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets N_REQ requesters share one UART transmitter.
// A grant latches the winner's payload and parity settings, strobes the UART
// for one cycle and then follows the UART BUSY flag until the frame is done.
// If BUSY never rises within BUSY_TMO cycles the frame is dropped and a
// one-cycle timeout pulse is raised.
//
// Handshakes: each REQ bit is held by its requester until it sees its ACK
// bit; ACK and DATA_VALID are both high for the single ISSUE cycle. The UART
// side has no ready: DATA_VALID is a strobe and TX_BUSY reports acceptance
// and completion.
module uart_tx_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BUSY_TMO   = 4,
  localparam int IW        = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]            req_par_en_i,
  input  logic [N_REQ-1:0]            req_par_typ_i,
  output logic [N_REQ-1:0]            ack_o,
  output logic [IW-1:0]               gnt_id_o,
  output logic [DATA_WIDTH-1:0]       p_data_o,
  output logic                        data_valid_o,
  output logic                        par_en_o,
  output logic                        par_typ_o,
  input  logic                        tx_busy_i,
  output logic                        arb_busy_o,
  output logic                        tmo_err_o,
  output logic [1:0]                  state_o
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [N_REQ-1:0]        ack_q, ack_d;
  logic                    tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic [IW-1:0]           gnt_q, gnt_d;

  logic                    rr_found;
  logic [IW-1:0]           rr_idx;
  logic [IW:0]             rr_sum;
  logic [IW-1:0]           rr_cand;

  // Round-robin search: first set REQ bit at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    rr_cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (rr_sum >= (IW+1)'(N_REQ)) begin
        rr_sum = rr_sum - (IW+1)'(N_REQ);
      end
      rr_cand = rr_sum[IW-1:0];
      if (!rr_found && req_i[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // Next-state logic: grant capture in IDLE, busy watchdog, completion tracking.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    tmo_d     = 1'b0;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    gnt_d     = gnt_q;
    case (state_q)
      S_IDLE: begin
        // External UART activity blocks new grants until BUSY falls.
        if (rr_found && !tx_busy_i) begin
          state_d        = S_ISSUE;
          data_d         = req_data_i[rr_idx*DATA_WIDTH +: DATA_WIDTH];
          par_en_d       = req_par_en_i[rr_idx];
          par_typ_d      = req_par_typ_i[rr_idx];
          gnt_d          = rr_idx;
          ack_d[rr_idx]  = 1'b1;
          ptr_d          = (rr_idx == IW'(N_REQ-1)) ? '0 : rr_idx + 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
        cnt_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TMO-1)) begin
          // UART never picked the frame up: drop it, no retry.
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight without an ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      tmo_q     <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      gnt_q     <= gnt_d;
    end
  end

  // Outputs decoded from state go to zero immediately with the async reset.
  always_comb begin
    data_valid_o = (state_q == S_ISSUE);
    arb_busy_o   = (state_q != S_IDLE);
    state_o      = state_q;
    ack_o        = ack_q;
    tmo_err_o    = tmo_q;
    p_data_o     = data_q;
    par_en_o     = par_en_q;
    par_typ_o    = par_typ_q;
    gnt_id_o     = gnt_q;
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed frames, a simple UART BUSY model and a
// scoreboard that checks every DATA_VALID strobe against an expected queue.
module tb_uart_tx_arb;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TMO = 4;
  localparam int IW  = 2;
  localparam int EW  = IW + 2 + DW;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_par_en_i;
  logic [N-1:0]    req_par_typ_i;
  logic [N-1:0]    ack_o;
  logic [IW-1:0]   gnt_id_o;
  logic [DW-1:0]   p_data_o;
  logic            data_valid_o;
  logic            par_en_o;
  logic            par_typ_o;
  logic            tx_busy_i;
  logic            arb_busy_o;
  logic            tmo_err_o;
  logic [1:0]      state_o;

  int checks = 0;
  int errors = 0;
  int dv_seen = 0;
  int uart_mode = 0;   // 0: BUSY model, 1: BUSY tied 0, 2: BUSY forced 1

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp = '0;

  uart_tx_arb #(.N_REQ(N), .DATA_WIDTH(DW), .BUSY_TMO(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .req_data_i    (req_data_i),
    .req_par_en_i  (req_par_en_i),
    .req_par_typ_i (req_par_typ_i),
    .ack_o         (ack_o),
    .gnt_id_o      (gnt_id_o),
    .p_data_o      (p_data_o),
    .data_valid_o  (data_valid_o),
    .par_en_o      (par_en_o),
    .par_typ_o     (par_typ_o),
    .tx_busy_i     (tx_busy_i),
    .arb_busy_o    (arb_busy_o),
    .tmo_err_o     (tmo_err_o),
    .state_o       (state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input int g, input bit typ, input bit en, input logic [DW-1:0] d);
    exp_q.push_back({IW'(g), typ, en, d});
  endfunction

  // UART model: BUSY rises the cycle after the strobe and stays up 3 cycles.
  initial begin
    tx_busy_i = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_mode == 2) begin
        tx_busy_i = 1'b1;
      end else if (uart_mode == 1) begin
        tx_busy_i = 1'b0;
      end else if (data_valid_o) begin
        @(negedge clk);
        tx_busy_i = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy_i = 1'b0;
      end else begin
        tx_busy_i = 1'b0;
      end
    end
  end

  // Monitor: pop on every strobe; outputs must hold while waiting on the UART.
  initial begin
    logic [EW-1:0] e;
    logic [N-1:0]  one;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (data_valid_o) begin
          dv_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got gnt %0d data %0h expected none", gnt_id_o, p_data_o);
          end else begin
            e = exp_q.pop_front();
            last_exp = e;
            one = 1;
            check("frame", {gnt_id_o, par_typ_o, par_en_o, p_data_o}, e);
            check("ack", ack_o, one << e[EW-1 -: IW]);
          end
        end else if (state_o == 2'd2 || state_o == 2'd3) begin
          check("hold", {ack_o, gnt_id_o, par_typ_o, par_en_o, p_data_o}, {{N{1'b0}}, last_exp});
        end
      end
    end
  end

  // Drive requesters that drop REQ on ACK until all pending frames are done.
  task automatic run_frames(input string name, input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      req_i = req_i & ~ack_o;
      if (req_i == '0 && state_o == 2'd0 && exp_q.size() == 0) break;
      n++;
      if (n >= budget) begin
        check({name, "_timeout"}, 64'(n), 64'(0));
        req_i = '0;
        exp_q.delete();
        break;
      end
    end
  endtask

  initial begin
    int n;
    int dv_before;
    rst = 1'b1;
    req_i = '0;
    req_data_i = '0;
    req_par_en_i = '0;
    req_par_typ_i = '0;
    repeat (2) @(negedge clk);
    check("reset_state", state_o, 2'd0);
    check("reset_outs", {ack_o, data_valid_o, tmo_err_o, arb_busy_o, p_data_o, par_en_o, par_typ_o, gnt_id_o}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Contention from ptr=0: grants 0,1,2,3
    req_data_i = {8'h43, 8'h32, 8'h21, 8'h10};
    req_par_en_i = 4'b0101;
    req_par_typ_i = 4'b0011;
    push(0, 1, 1, 8'h10);
    push(1, 1, 0, 8'h21);
    push(2, 0, 1, 8'h32);
    push(3, 0, 0, 8'h43);
    req_i = 4'b1111;
    run_frames("contention", 200);

    // Single request, strobe one cycle after REQ is sampled
    req_data_i[7:0] = 8'h81;
    req_par_en_i = '0;
    req_par_typ_i = '0;
    push(0, 0, 0, 8'h81);
    req_i = 4'b0001;
    @(negedge clk);
    check("latency", data_valid_o, 1'b1);
    check("arb_busy", arb_busy_o, 1'b1);
    req_i = req_i & ~ack_o;
    run_frames("single", 50);

    // Parity routing from requester 2, ptr becomes 3
    req_data_i[23:16] = 8'hFF;
    req_par_en_i = 4'b0100;
    req_par_typ_i = 4'b0100;
    push(2, 1, 1, 8'hFF);
    req_i = 4'b0100;
    run_frames("parity", 50);

    // Wrap: ptr=3, REQ=1001 -> 3 then 0
    req_data_i[31:24] = 8'hA5;
    req_data_i[7:0] = 8'h5A;
    req_par_en_i = '0;
    req_par_typ_i = '0;
    push(3, 0, 0, 8'hA5);
    push(0, 0, 0, 8'h5A);
    req_i = 4'b1001;
    run_frames("wrap", 100);

    // External BUSY in IDLE blocks the grant (ptr=1, REQ=1000 -> 3 after release)
    uart_mode = 2;
    @(negedge clk);
    dv_before = dv_seen;
    req_i = 4'b1000;
    repeat (8) @(negedge clk);
    check("busy_block_state", state_o, 2'd0);
    check("busy_block_strobes", 64'(dv_seen - dv_before), 64'(0));
    push(3, 0, 0, 8'hA5);
    uart_mode = 0;
    run_frames("busy_release", 50);

    // Timeout: BUSY tied 0, TMO_ERR 5 cycles after the strobe
    uart_mode = 1;
    @(negedge clk);
    req_data_i[15:8] = 8'h3C;
    push(1, 0, 0, 8'h3C);
    req_i = 4'b0010;
    n = 0;
    while (!data_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    req_i = req_i & ~ack_o;
    check("tmo_strobe_seen", data_valid_o, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tmo_err_o && n < 20);
    check("tmo_delay", 64'(n), 64'(5));
    check("tmo_state_idle", state_o, 2'd0);
    @(negedge clk);
    check("tmo_one_cycle", tmo_err_o, 1'b0);

    // The next grant follows normally
    uart_mode = 0;
    @(negedge clk);
    push(1, 0, 0, 8'h3C);
    req_i = 4'b0010;
    run_frames("after_tmo", 50);

    // Reset in WAIT_DONE; without it REQ=1100 would go to 3 first
    req_data_i[23:16] = 8'h77;
    push(2, 0, 0, 8'h77);
    req_i = 4'b0100;
    n = 0;
    while (state_o != 2'd3 && n < 30) begin
      @(negedge clk);
      req_i = req_i & ~ack_o;
      n++;
    end
    check("reached_wait_done", state_o, 2'd3);
    #1 rst = 1'b1;
    #1;
    check("async_reset_state", state_o, 2'd0);
    check("async_reset_outs", {ack_o, data_valid_o, tmo_err_o, arb_busy_o, p_data_o, par_en_o, par_typ_o, gnt_id_o}, 0);
    req_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(2, 0, 0, 8'h77);
    push(3, 0, 0, 8'hA5);
    req_i = 4'b1100;
    run_frames("after_reset", 100);

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001: Parameter N_REQ, default 4, is the number of requesters sharing one UART_TX (range 2..8).
REQ-002: Parameter DATA_WIDTH, default 8, is the frame payload width.
REQ-003: Parameter BUSY_TMO, default 4, is the number of cycles to wait for TX_BUSY after issue (range 1..15).
REQ-004: CLK  input  1  is the single clock; all state updates on its rising edge.
REQ-005: RST  input  1  is the reset: asynchronous, active-high.
REQ-006: REQ  input  N_REQ  is the per-requester frame request; it is held until the matching ACK.
REQ-007: REQ_DATA  input  N_REQ*DATA_WIDTH  is the per-requester payload; slice i is bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008: REQ_PAR_EN  input  N_REQ  is the per-requester parity enable.
REQ-009: REQ_PAR_TYP  input  N_REQ  is the per-requester parity type (0 even, 1 odd).
REQ-010: ACK  output  N_REQ  is a one-hot, one-cycle pulse marking that requester's frame as taken.
REQ-011: GNT_ID  output  clog2(N_REQ)  is the index of the current or last granted requester.
REQ-012: P_DATA  output  DATA_WIDTH  is the payload to the UART_TX.
REQ-013: DATA_VALID  output  1  is the frame strobe to the UART_TX.
REQ-014: PAR_EN  output  1  is the parity enable to the UART_TX.
REQ-015: PAR_TYP  output  1  is the parity type to the UART_TX.
REQ-016: TX_BUSY  input  1  is the UART_TX BUSY flag.
REQ-017: ARB_BUSY  output  1  is high whenever the state is not IDLE.
REQ-018: TMO_ERR  output  1  is a one-cycle pulse on busy-timeout.

Function
REQ-019: The FSM SHALL have four states: IDLE, ISSUE, WAIT_BUSY and WAIT_DONE, encoded in 2 bits.
REQ-020: IDLE -> ISSUE at the edge where |REQ=1 and TX_BUSY=0; otherwise the FSM SHALL stay in IDLE.
REQ-021: At the IDLE->ISSUE edge, the block SHALL register the following from the granted index g: P_DATA, PAR_EN and PAR_TYP from slice g; GNT_ID=g; ACK[g]=1.
REQ-022: Arbitration SHALL be round-robin: g is the first index with REQ set, searching from pointer ptr upward with wrap modulo N_REQ.
REQ-023: After a grant, ptr SHALL become (g+1) mod N_REQ, wrapping from N_REQ-1 to 0.
REQ-024: DATA_VALID SHALL be high only while the state is ISSUE, for exactly one cycle; ACK SHALL be high in the same cycle; the latency from sampled REQ to DATA_VALID is 1 cycle.
REQ-025: ISSUE -> WAIT_BUSY unconditionally; the timeout counter SHALL be cleared to 0 on entry.
REQ-026: WAIT_BUSY -> WAIT_DONE when TX_BUSY=1; otherwise the counter increments.
REQ-027: WAIT_BUSY -> IDLE when the counter reaches BUSY_TMO-1 with TX_BUSY=0; TMO_ERR SHALL pulse at that edge and the frame is dropped with no retry.
REQ-028: WAIT_DONE -> IDLE when TX_BUSY=0; a new grant requires at least one cycle in IDLE.
REQ-029: P_DATA, PAR_EN, PAR_TYP and GNT_ID SHALL be held stable from ISSUE until the next grant.
REQ-030: REQ changes outside IDLE SHALL be ignored; a REQ deasserted before grant SHALL lose its turn and leave ptr unchanged.
REQ-031: Simultaneous requests SHALL be resolved by ptr alone; a requester holding REQ continuously is served at most once per N_REQ grants while others are pending.
REQ-032: If TX_BUSY=1 while in IDLE (external activity), no grant SHALL occur until it falls.

Reset
REQ-033: While RST=1, the state SHALL be IDLE with ptr=0, counter=0, ACK=0, DATA_VALID=0, TMO_ERR=0, ARB_BUSY=0, P_DATA=0, PAR_EN=0, PAR_TYP=0 and GNT_ID=0, applied immediately without waiting for CLK.
REQ-034: Reset asserted mid-frame SHALL abort the frame without generating an ACK; the first grant after release SHALL start from index 0.

Verification
REQ-035: Single request: REQ=0001, REQ_DATA[7:0]=8'h81, PAR_EN=0, with TX_BUSY driven by UART_TX -> one-cycle DATA_VALID one cycle after sampling, P_DATA=8'h81, ACK=0001, GNT_ID=0.
REQ-036: Contention: REQ=1111 held with ACK-driven drop -> grant order 0,1,2,3 with GNT_ID sequence 0,1,2,3; each ACK comes only after the prior TX_BUSY falls.
REQ-037: Wrap: ptr=3 and REQ=1001 -> grant 3 then 0 (ptr wraps to 0, then 1).
REQ-038: Parity routing: requester 2 with PAR_EN=1, PAR_TYP=1, data 8'hFF -> PAR_EN=1 and PAR_TYP=1 on the UART_TX port, held through WAIT_DONE.
REQ-039: Timeout: TX_BUSY tied 0, REQ=0010 -> TMO_ERR pulses 1+BUSY_TMO cycles after DATA_VALID (5 at default); the FSM returns to IDLE and the next grant follows.
REQ-040: Reset in WAIT_DONE -> all outputs are 0 asynchronously; after release, REQ=1100 is granted to index 2 first.
